// File: rtl/main_mem_responder_if.sv
// Cache <-> main-memory responder bus: request, write-beat and read-beat
// channels plus the transaction-complete pulse. The cache side uses the
// master modport; the responder uses the slave modport.
interface main_mem_responder_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int BLOCK_ADDR_WIDTH = 12
);

  logic                        req_valid;
  logic                        req_ready;
  logic                        req_write;
  logic [BLOCK_ADDR_WIDTH-1:0] req_block_addr;

  logic                        wr_valid;
  logic                        wr_ready;
  logic [DATA_WIDTH-1:0]       wr_data;

  logic                        rd_valid;
  logic [DATA_WIDTH-1:0]       rd_data;
  logic                        rd_last;

  logic                        resp_done;

  modport master (
    output req_valid, req_write, req_block_addr, wr_valid, wr_data,
    input  req_ready, wr_ready, rd_valid, rd_data, rd_last, resp_done
  );

  modport slave (
    input  req_valid, req_write, req_block_addr, wr_valid, wr_data,
    output req_ready, wr_ready, rd_valid, rd_data, rd_last, resp_done
  );

endinterface

// File: rtl/main_mem_responder.sv
// Block-granular main-memory responder. Accepts one block request at a time,
// waits ACCESS_LATENCY cycles, then streams WORDS_PER_BLOCK words out (read)
// or accepts them in (write), and finishes with a one-cycle resp_done pulse.
// The memory array is never reset; only the control registers are.
//
// Build option: define MEM_ZERO_INIT_EN to clear the whole array at time 0 so
// that never-written blocks read as zero. Without it the array starts unknown.
module main_mem_responder #(
  parameter int DATA_WIDTH       = 32,
  parameter int BLOCK_ADDR_WIDTH = 12,
  parameter int OFFSET_WIDTH     = 4,
  parameter int ACCESS_LATENCY   = 4
) (
  input logic                 clk,
  input logic                 reset,
  main_mem_responder_if.slave bus
);

  localparam int WORDS_PER_BLOCK = 1 << OFFSET_WIDTH;
  localparam int LAT_W           = $clog2(ACCESS_LATENCY + 1);
  localparam int MEM_AW          = BLOCK_ADDR_WIDTH + OFFSET_WIDTH;
  localparam int MEM_DEPTH       = 1 << MEM_AW;

  localparam logic [OFFSET_WIDTH-1:0] LAST_BEAT = OFFSET_WIDTH'(WORDS_PER_BLOCK - 1);
  localparam logic [LAT_W-1:0]        LAT_INIT  = LAT_W'(ACCESS_LATENCY - 1);
  localparam logic [LAT_W-1:0]        LAT_ONE   = LAT_W'(1);
  localparam logic [OFFSET_WIDTH-1:0] BEAT_ONE  = OFFSET_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT     = 3'd1,
    RD_BURST = 3'd2,
    WR_BURST = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t                      state;
  state_t                      state_nxt;
  logic [BLOCK_ADDR_WIDTH-1:0] addr;
  logic                        is_write;
  logic [LAT_W-1:0]            lat_cnt;
  logic [OFFSET_WIDTH-1:0]     beat;

  logic [DATA_WIDTH-1:0]       mem [MEM_DEPTH];

  logic                        req_fire;
  logic                        wr_fire;
  logic [MEM_AW-1:0]           mem_idx;

  // A request is taken only while idle; write beats land only during the burst.
  assign req_fire = bus.req_valid && (state == IDLE);
  assign wr_fire  = bus.wr_valid  && (state == WR_BURST);
  assign mem_idx  = {addr, beat};

`ifdef MEM_ZERO_INIT_EN
  // Simulation-time clear so unwritten blocks read back as zero.
  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) begin
      mem[i] = '0;
    end
  end
`endif

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Control counters: latency countdown, beat index and transaction direction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_cnt  <= '0;
      beat     <= '0;
      is_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            is_write <= bus.req_write;
            lat_cnt  <= LAT_INIT;
            beat     <= '0;
          end
        end
        WAIT: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LAT_ONE;
          end
        end
        RD_BURST: begin
          // Wraps back to 0 after the last beat.
          beat <= beat + BEAT_ONE;
        end
        WR_BURST: begin
          if (bus.wr_valid) begin
            beat <= beat + BEAT_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Block address is captured on request acceptance and held for the burst.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      addr <= bus.req_block_addr;
    end
  end

  // Memory write port; a reset drops the FSM to IDLE, which stops further writes.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[mem_idx] <= bus.wr_data;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt == '0) begin
          state_nxt = is_write ? WR_BURST : RD_BURST;
        end
      end
      RD_BURST: begin
        if (beat == LAST_BEAT) begin
          state_nxt = RESP;
        end
      end
      WR_BURST: begin
        if (bus.wr_valid && (beat == LAST_BEAT)) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from state; read data is forced to 0 off-burst.
  always_comb begin
    bus.req_ready = 1'b0;
    bus.wr_ready  = 1'b0;
    bus.rd_valid  = 1'b0;
    bus.rd_data   = '0;
    bus.rd_last   = 1'b0;
    bus.resp_done = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
      end
      RD_BURST: begin
        bus.rd_valid = 1'b1;
        bus.rd_data  = mem[mem_idx];
        bus.rd_last  = (beat == LAST_BEAT);
      end
      WR_BURST: begin
        bus.wr_ready = 1'b1;
      end
      RESP: begin
        bus.resp_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder: a shadow memory model supplies
// expected read words, which are queued when a read is issued and popped as
// beats arrive.
module tb_main_mem_responder;

  localparam int L = 4;
  localparam int W = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  main_mem_responder_if #(.DATA_WIDTH(32), .BLOCK_ADDR_WIDTH(12)) bus ();

  main_mem_responder #(
    .DATA_WIDTH      (32),
    .BLOCK_ADDR_WIDTH(12),
    .OFFSET_WIDTH    (4),
    .ACCESS_LATENCY  (L)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] sb [$];
  logic [31:0] model [int];
  logic [31:0] blk [W];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int key(input logic [11:0] a, input int i);
    return int'(a) * W + i;
  endfunction

  function automatic logic [31:0] model_rd(input logic [11:0] a, input int i);
    int k;
    k = key(a, i);
    return model.exists(k) ? model[k] : 32'h0;
  endfunction

  task automatic wait_ready();
    int g;
    g = 0;
    while (bus.req_ready !== 1'b1 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    chk("req_ready_wait", bus.req_ready, 1'b1);
  endtask

  // Called in cycle 1 after acceptance; returns in the resp_done cycle.
  task automatic collect_read(input bit timing);
    int          cyc;
    int          beats;
    bit          done;
    logic [31:0] e;
    cyc   = 1;
    beats = 0;
    done  = 1'b0;
    while (!done && cyc < 60) begin
      chk("req_ready_busy", bus.req_ready, 1'b0);
      if (bus.rd_valid === 1'b1) begin
        if (beats == 0 && timing) chk("first_beat_cycle", cyc, L + 1);
        e = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
        chk("rd_data", bus.rd_data, e);
        chk("rd_last", bus.rd_last, (beats == W - 1));
        beats++;
      end else begin
        chk("rd_data_zero", bus.rd_data, 32'h0);
      end
      if (bus.resp_done === 1'b1) begin
        done = 1'b1;
        chk("beat_count", beats, W);
        if (timing) chk("resp_cycle", cyc, L + W + 1);
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("resp_done_seen", done, 1'b1);
  endtask

  task automatic do_read(input logic [11:0] a, input bit timing);
    for (int i = 0; i < W; i++) sb.push_back(model_rd(a, i));
    wait_ready();
    bus.req_valid      = 1'b1;
    bus.req_write      = 1'b0;
    bus.req_block_addr = a;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    collect_read(timing);
  endtask

  // Writes blk[] to block a; gaps_in[b] inserts one idle cycle before beat b;
  // abort_at >= 0 asserts reset once that many beats have been accepted.
  task automatic do_write(input logic [11:0] a, input logic [15:0] gaps_in, input int abort_at);
    logic [15:0] gaps;
    int          beat;
    int          g;
    gaps = gaps_in;
    beat = 0;
    wait_ready();
    bus.req_valid      = 1'b1;
    bus.req_write      = 1'b1;
    bus.req_block_addr = a;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    g = 1;
    while (bus.wr_ready !== 1'b1 && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    chk("wr_first_cycle", g, L + 1);
    while (beat < W && g < 200) begin
      chk("wr_ready_held", bus.wr_ready, 1'b1);
      if (beat == abort_at) begin
        bus.wr_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("abort_req_ready", bus.req_ready, 1'b1);
        chk("abort_wr_ready", bus.wr_ready, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_idle_next", bus.req_ready, 1'b1);
        chk("abort_no_resp", bus.resp_done, 1'b0);
        return;
      end
      if (gaps[beat]) begin
        bus.wr_valid = 1'b0;
        gaps[beat]   = 1'b0;
      end else begin
        bus.wr_valid = 1'b1;
        bus.wr_data  = blk[beat];
        model[key(a, beat)] = blk[beat];
        beat++;
      end
      @(posedge clk); #1;
      g++;
    end
    bus.wr_valid = 1'b0;
    chk("wr_resp_done", bus.resp_done, 1'b1);
    chk("wr_ready_resp", bus.wr_ready, 1'b0);
  endtask

  initial begin
    bus.req_valid      = 1'b0;
    bus.req_write      = 1'b0;
    bus.req_block_addr = '0;
    bus.wr_valid       = 1'b0;
    bus.wr_data        = '0;

    // 1. reset and idle outputs
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_rd_valid", bus.rd_valid, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_req_ready", bus.req_ready, 1'b1);
    chk("idle_rd_valid", bus.rd_valid, 1'b0);
    chk("idle_wr_ready", bus.wr_ready, 1'b0);
    chk("idle_resp_done", bus.resp_done, 1'b0);
    chk("idle_rd_last", bus.rd_last, 1'b0);
    chk("idle_rd_data", bus.rd_data, 32'h0);

    // 2. read of a zero block with latency/burst timing
`ifndef MEM_ZERO_INIT_EN
    for (int i = 0; i < W; i++) blk[i] = 32'h0;
    do_write(12'h005, 16'h0000, -1);
`endif
    do_read(12'h005, 1'b1);

    // 3. write with gaps, then read back
    for (int i = 0; i < W; i++) blk[i] = 32'h1000 + i;
    do_write(12'hABC, 16'h0088, -1);
    do_read(12'hABC, 1'b1);

    // 4. req_valid held high: back-to-back reads of 0x001 and 0x002
    for (int i = 0; i < W; i++) blk[i] = 32'h0001_0000 + i;
    do_write(12'h001, 16'h0000, -1);
    for (int i = 0; i < W; i++) blk[i] = 32'h0002_0000 + 32'(i * 3);
    do_write(12'h002, 16'h0000, -1);
    for (int i = 0; i < W; i++) sb.push_back(model_rd(12'h001, i));
    wait_ready();
    bus.req_valid      = 1'b1;
    bus.req_write      = 1'b0;
    bus.req_block_addr = 12'h001;
    @(posedge clk); #1;
    bus.req_block_addr = 12'h002;
    collect_read(1'b1);
    for (int i = 0; i < W; i++) sb.push_back(model_rd(12'h002, i));
    @(posedge clk); #1;
    chk("b2b_ready_after_resp", bus.req_ready, 1'b1);
    chk("b2b_idle_rd_valid", bus.rd_valid, 1'b0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    collect_read(1'b1);

    // 5. reset in the middle of a write-back
    for (int i = 0; i < W; i++) blk[i] = 32'hFFFF_FFFF;
    do_write(12'h010, 16'h0000, -1);
    for (int i = 0; i < W; i++) blk[i] = 32'h0;
    do_write(12'h010, 16'h0000, 5);
    do_read(12'h010, 1'b1);

    // 6. maximum block address, block 0 untouched
    for (int i = 0; i < W; i++) blk[i] = 32'hA5A5_0000 + i;
    do_write(12'h000, 16'h0000, -1);
    for (int i = 0; i < W; i++) blk[i] = 32'hC3C3_0000 + 32'(i * 7);
    do_write(12'hFFF, 16'h0000, -1);
    do_read(12'hFFF, 1'b1);
    do_read(12'h000, 1'b1);

    chk("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
